spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the transfer word length in bits.
REQ-002 SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clock cycles; legal range is at least 1.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: transfer request from the CPU.
REQ-006 SHALL have port tx_data, input, DATA_WIDTH bits: word to transmit.
REQ-007 SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port rx_data, output, DATA_WIDTH bits: last word received.
REQ-010 SHALL have port sclk, output, 1 bit: SPI serial clock.
REQ-011 SHALL have port mosi, output, 1 bit: serial data out.
REQ-012 SHALL have port miso, input, 1 bit: serial data in.
REQ-013 SHALL have port cs_n, output, 1 bit: active-low chip select.

Function
REQ-014 SHALL operate in SPI mode 0: CPOL=0, CPHA=0, MSB first.
REQ-015 SHALL use a state machine with states IDLE, SETUP, TRANSFER and FINISH, held in register spi_state.
REQ-016 In IDLE with start=1, SHALL capture tx_data into the shift register and enter SETUP on the next edge; tx_data changes after capture SHALL be ignored.
REQ-017 In SETUP, SHALL hold cs_n=0 and sclk=0 and drive mosi with the captured MSB for CLK_DIV cycles, then enter TRANSFER.
REQ-018 In TRANSFER, SHALL toggle sclk every CLK_DIV cycles, for 2*DATA_WIDTH toggles in total.
REQ-019 SHALL sample miso into the receive shift register on each rising sclk edge.
REQ-020 SHALL shift mosi to the next bit on each falling sclk edge except the last.
REQ-021 After the final falling sclk edge, SHALL enter FINISH, holding cs_n=0 and sclk=0 for CLK_DIV cycles, then enter IDLE.
REQ-022 On the edge that returns the block to IDLE, SHALL update rx_data and drive done=1 for exactly one cycle.
REQ-023 busy SHALL be 1 in SETUP, TRANSFER and FINISH, and 0 in IDLE.
REQ-024 busy SHALL stay high for exactly CLK_DIV*(2*DATA_WIDTH+2) cycles per transfer.
REQ-025 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-026 start asserted in the same cycle as done=1 SHALL be accepted, giving back-to-back transfers with one IDLE cycle between them.
REQ-027 rx_data SHALL hold its value until the next completed transfer.
REQ-028 cs_n SHALL be 1 and sclk SHALL be 0 whenever the state is IDLE.

Reset
REQ-029 On reset=1, SHALL set spi_state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, and clear both shift registers and the divider counter.
REQ-030 A reset during any non-IDLE state SHALL abort the transfer; no done pulse SHALL follow, and rx_data SHALL read 0.
REQ-031 start asserted together with reset SHALL be ignored.

Structure
REQ-032 Package spi_pkg SHALL hold typedef enum spi_state_t {IDLE, SETUP, TRANSFER, FINISH}, so that the CPU and benches can print spi_state by name.
REQ-033 spi_pkg SHALL hold the default DATA_WIDTH and CLK_DIV constants.
REQ-034 The block SHALL contain one sub-module, spi_clk_div, a CLK_DIV tick generator with enable, cleared on leaving IDLE.
REQ-035 Edge detection, bit counter and shift registers SHALL reside in spi_master.

Verification
REQ-036 Scenario, DATA_WIDTH=8, CLK_DIV=2, miso looped to mosi, start with tx_data=0xA5 -> busy high for 36 cycles; 8 sclk pulses; mosi bits 1,0,1,0,0,1,0,1; rx_data=0xA5 with done pulse.
REQ-037 Scenario, miso tied to 1, tx_data=0x3C -> rx_data=0xFF; mosi carries 0x3C MSB first.
REQ-038 Scenario, start re-asserted mid-transfer with tx_data=0x11 -> ignored; first transfer completes unchanged; no extra done pulse.
REQ-039 Scenario, start held high through done -> second transfer begins one cycle after done; two done pulses 37 cycles apart.
REQ-040 Scenario, reset asserted during TRANSFER after 3 bits -> next cycle cs_n=1, sclk=0, busy=0, rx_data=0, and no done pulse.
REQ-041 Scenario, CLK_DIV=1, DATA_WIDTH=32, tx_data=0xDEADBEEF in loopback -> busy for 66 cycles; rx_data=0xDEADBEEF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI master types and default sizing.
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 32;
  localparam int unsigned SPI_CLK_DIV    = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    FINISH
  } spi_state_t;

endpackage

// File: rtl/spi_master_clk_div.sv
// Divider tick generator: pulses o_tick once every CLK_DIV enabled cycles.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Held at zero while disabled, so every enable window starts a fresh period.
  always_ff @(posedge clock) begin
    if (reset || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, single-word transfers with a setup and finish
// phase of CLK_DIV cycles each around the 2*DATA_WIDTH sclk half-periods.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = SPI_CLK_DIV
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int unsigned   EW        = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  spi_state_t            spi_state;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [EW-1:0]         r_edge_cnt;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_div_en;
  logic                  w_tick;
  logic                  w_rise;
  logic                  w_fall;

  assign w_div_en = (spi_state != IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clock (clock),
    .reset (reset),
    .i_en  (w_div_en),
    .o_tick(w_tick)
  );

  // A tick in TRANSFER toggles sclk; the current level tells which edge it makes.
  assign w_rise = w_tick && (spi_state == TRANSFER) && !r_sclk;
  assign w_fall = w_tick && (spi_state == TRANSFER) &&  r_sclk;

  always_ff @(posedge clock) begin
    if (reset) begin
      spi_state  <= IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_edge_cnt <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (spi_state)
        IDLE: begin
          if (start) begin
            r_tx       <= tx_data;
            r_rx       <= '0;
            r_edge_cnt <= '0;
            r_cs_n     <= 1'b0;
            r_busy     <= 1'b1;
            spi_state  <= SETUP;
          end
        end
        SETUP: begin
          if (w_tick) spi_state <= TRANSFER;
        end
        TRANSFER: begin
          if (w_rise) begin
            r_sclk     <= 1'b1;
            r_edge_cnt <= r_edge_cnt + EW'(1);
            r_rx       <= {r_rx[DATA_WIDTH-2:0], miso};
          end else if (w_fall) begin
            r_sclk     <= 1'b0;
            r_edge_cnt <= r_edge_cnt + EW'(1);
            if (r_edge_cnt == LAST_EDGE) begin
              spi_state <= FINISH;
            end else begin
              r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        FINISH: begin
          if (w_tick) begin
            spi_state <= IDLE;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
          end
        end
        default: spi_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign cs_n    = r_cs_n;
  assign mosi    = r_tx[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an 8-bit/div-2 instance and a 32-bit/div-1 instance.
module tb_spi_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        busy, done, sclk, mosi, cs_n;
  logic [7:0]  rx_data;
  logic        loop = 1'b1;
  logic        miso_val = 1'b0;
  logic        miso;

  logic        start2 = 1'b0;
  logic [31:0] tx2 = '0;
  logic        busy2, done2, sclk2, mosi2, cs_n2, miso2;
  logic [31:0] rx2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  assign miso  = loop ? mosi : miso_val;
  assign miso2 = mosi2;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) u_dut (
    .clock(clock), .reset(reset), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master #(.DATA_WIDTH(32), .CLK_DIV(1)) u_dut_wide (
    .clock(clock), .reset(reset), .start(start2), .tx_data(tx2),
    .busy(busy2), .done(done2), .rx_data(rx2), .sclk(sclk2),
    .mosi(mosi2), .miso(miso2), .cs_n(cs_n2)
  );

  int          cyc = 0, busy_cnt = 0, pulses = 0, done_cnt = 0;
  int          done_last = 0, done_prev = 0, busy2_cnt = 0, done2_cnt = 0;
  logic [63:0] mosi_hist = '0;
  logic        sclk_q = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (busy === 1'b1) busy_cnt++;
    if (sclk === 1'b1 && sclk_q === 1'b0) begin
      pulses++;
      mosi_hist = {mosi_hist[62:0], mosi};
    end
    sclk_q = sclk;
    if (done === 1'b1) begin
      done_cnt++;
      done_prev = done_last;
      done_last = cyc;
    end
    if (busy2 === 1'b1) busy2_cnt++;
    if (done2 === 1'b1) done2_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] d);
    tx_data = d;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; tx_data = 8'hFF; start2 = 1'b1;
    tick(2);
    n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    n_cmp++; if (cs_n2 !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n2: got %b want 1", cs_n2); end
    reset = 1'b0; start = 1'b0; start2 = 1'b0;
    tick(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_loopback_a5;
    int b0, p0, d0;
    bit ok;
    loop = 1'b1;
    b0 = busy_cnt; p0 = pulses; d0 = done_cnt;
    pulse_start(8'hA5);
    wait_done(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL a5_done_timeout: got %b want 1", ok); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL a5_rx: got %h want a5", rx_data); end
    n_cmp++; if (cs_n !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL a5_idle_at_done: cs_n=%b busy=%b want 1/0", cs_n, busy); end
    tick(2);
    n_cmp++; if (busy_cnt - b0 !== 36) begin n_bad++; $display("FAIL a5_busy_cycles: got %0d want 36", busy_cnt - b0); end
    n_cmp++; if (pulses - p0 !== 8) begin n_bad++; $display("FAIL a5_sclk_pulses: got %0d want 8", pulses - p0); end
    n_cmp++; if (mosi_hist[7:0] !== 8'hA5) begin n_bad++; $display("FAIL a5_mosi_bits: got %b want 10100101", mosi_hist[7:0]); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL a5_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_miso_ones;
    int p0;
    bit ok;
    loop = 1'b0; miso_val = 1'b1;
    p0 = pulses;
    pulse_start(8'h3C);
    wait_done(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ones_done_timeout: got %b want 1", ok); end
    n_cmp++; if (rx_data !== 8'hFF) begin n_bad++; $display("FAIL ones_rx: got %h want ff", rx_data); end
    tick(2);
    n_cmp++; if (mosi_hist[7:0] !== 8'h3C || pulses - p0 !== 8) begin n_bad++; $display("FAIL ones_mosi: got %h/%0d want 3c/8", mosi_hist[7:0], pulses - p0); end
    loop = 1'b1; miso_val = 1'b0;
  endtask

  task automatic test_start_ignored;
    int d0, b0;
    bit ok;
    d0 = done_cnt; b0 = busy_cnt;
    pulse_start(8'h5A);
    tick(10);
    n_cmp++; if (busy !== 1'b1 || cs_n !== 1'b0) begin n_bad++; $display("FAIL ign_mid_state: busy=%b cs_n=%b want 1/0", busy, cs_n); end
    n_cmp++; if (rx_data !== 8'hFF) begin n_bad++; $display("FAIL ign_rx_held: got %h want ff", rx_data); end
    pulse_start(8'h11);
    wait_done(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ign_done_timeout: got %b want 1", ok); end
    n_cmp++; if (rx_data !== 8'h5A) begin n_bad++; $display("FAIL ign_rx: got %h want 5a", rx_data); end
    tick(40);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL ign_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (mosi_hist[7:0] !== 8'h5A) begin n_bad++; $display("FAIL ign_mosi: got %h want 5a", mosi_hist[7:0]); end
    n_cmp++; if (busy_cnt - b0 !== 36) begin n_bad++; $display("FAIL ign_busy_cycles: got %0d want 36", busy_cnt - b0); end
  endtask

  task automatic test_back_to_back;
    int d0;
    bit ok;
    d0 = done_cnt;
    tx_data = 8'hC3; start = 1'b1;
    wait_done(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_first_timeout: got %b want 1", ok); end
    n_cmp++; if (rx_data !== 8'hC3) begin n_bad++; $display("FAIL b2b_first_rx: got %h want c3", rx_data); end
    tx_data = 8'h96;
    tick(1);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: busy got %b want 1", busy); end
    wait_done(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_second_timeout: got %b want 1", ok); end
    n_cmp++; if (rx_data !== 8'h96) begin n_bad++; $display("FAIL b2b_second_rx: got %h want 96", rx_data); end
    tick(2);
    n_cmp++; if (done_cnt - d0 !== 2) begin n_bad++; $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt - d0); end
    n_cmp++; if (done_last - done_prev !== 37) begin n_bad++; $display("FAIL b2b_done_spacing: got %0d want 37", done_last - done_prev); end
  endtask

  task automatic test_reset_abort;
    int d0, p0;
    d0 = done_cnt; p0 = pulses;
    pulse_start(8'hF0);
    for (int i = 0; i < 100 && (pulses - p0) < 3; i++) tick(1);
    n_cmp++; if (pulses - p0 < 3) begin n_bad++; $display("FAIL abort_3bits_timeout: got %0d pulses want 3", pulses - p0); end
    n_cmp++; if (rx_data !== 8'h96) begin n_bad++; $display("FAIL abort_rx_held: got %h want 96", rx_data); end
    reset = 1'b1;
    tick(1);
    n_cmp++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_outputs: cs_n=%b sclk=%b busy=%b want 1/0/0", cs_n, sclk, busy); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL abort_rx: got %h want 00", rx_data); end
    reset = 1'b0;
    tick(60);
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_wide;
    int  b0, d0;
    bit  ok;
    b0 = busy2_cnt; d0 = done2_cnt;
    tx2 = 32'hDEADBEEF; start2 = 1'b1;
    tick(1);
    start2 = 1'b0; tx2 = 32'h0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      if (done2 === 1'b1) ok = 1'b1;
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wide_done_timeout: got %b want 1", ok); end
    n_cmp++; if (rx2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wide_rx: got %h want deadbeef", rx2); end
    tick(2);
    n_cmp++; if (busy2_cnt - b0 !== 66) begin n_bad++; $display("FAIL wide_busy_cycles: got %0d want 66", busy2_cnt - b0); end
    n_cmp++; if (done2_cnt - d0 !== 1) begin n_bad++; $display("FAIL wide_done_pulses: got %0d want 1", done2_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_miso_ones();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
